// File: rtl/axil_csr_slave_pkg.sv
// Shared widths and state encodings for the AXI-Lite CSR slave.
// Imported by the interface, the register bank and the top level.
package axil_csr_slave_pkg;

    localparam int AXIL_DATA_WIDTH = 32;
    localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_COMMIT  = 2'd1,
        W_RESP    = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axil_csr_slave_if.sv
// AXI-Lite register-slice facing bus (no response codes).
// The slave modport is the CSR side; the master modport is the slice side.
interface axil_csr_slave_if #(
    parameter int AXIL_ADDR_WIDTH = 32
) ();
    import axil_csr_slave_pkg::*;

    logic [AXIL_ADDR_WIDTH-1:0] awaddr_s;
    logic                       awvalid_s;
    logic                       awready_s;
    logic [AXIL_DATA_WIDTH-1:0] wdata_s;
    logic [AXIL_STRB_WIDTH-1:0] wstrb_s;
    logic                       wvalid_s;
    logic                       wready_s;
    logic                       bvalid_s;
    logic                       bready_s;
    logic [AXIL_ADDR_WIDTH-1:0] araddr_s;
    logic                       arvalid_s;
    logic                       arready_s;
    logic [AXIL_DATA_WIDTH-1:0] rdata_s;
    logic                       rvalid_s;
    logic                       rready_s;

    modport master (
        output awaddr_s, awvalid_s, wdata_s, wstrb_s, wvalid_s, bready_s,
               araddr_s, arvalid_s, rready_s,
        input  awready_s, wready_s, bvalid_s, arready_s, rdata_s, rvalid_s
    );

    modport slave (
        input  awaddr_s, awvalid_s, wdata_s, wstrb_s, wvalid_s, bready_s,
               araddr_s, arvalid_s, rready_s,
        output awready_s, wready_s, bvalid_s, arready_s, rdata_s, rvalid_s
    );

endinterface

// File: rtl/axil_csr_slave_bank.sv
// CSR array with byte-strobed write port, per-register write pulses and
// a read mux that substitutes status for read-only and zero for unmapped.
module axil_csr_slave_bank
    import axil_csr_slave_pkg::*;
#(
    parameter int                         AXIL_ADDR_WIDTH = 32,
    parameter int                         REG_NUM         = 16,
    parameter logic [AXIL_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter logic [REG_NUM-1:0]         RO_MASK         = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic [AXIL_ADDR_WIDTH-1:0]         wr_addr_i,
    input  logic [AXIL_DATA_WIDTH-1:0]         wr_data_i,
    input  logic [AXIL_STRB_WIDTH-1:0]         wr_strb_i,
    input  logic [AXIL_ADDR_WIDTH-1:0]         rd_addr_i,
    output logic [AXIL_DATA_WIDTH-1:0]         rd_data_o,
    output logic [REG_NUM*AXIL_DATA_WIDTH-1:0] reg_out_o,
    output logic [REG_NUM-1:0]                 reg_wr_pulse_o,
    input  logic [REG_NUM*AXIL_DATA_WIDTH-1:0] status_in_i
);
    localparam int WA_W = AXIL_ADDR_WIDTH - 2;

    // Returns {out_of_range, index}; the MSB of the widened difference is the borrow for addr < base.
    function automatic logic [WA_W:0] decode(input logic [WA_W-1:0] word_addr);
        logic [WA_W:0] diff;
        diff = {1'b0, word_addr} - {1'b0, BASE_ADDR[AXIL_ADDR_WIDTH-1:2]};
        return {diff[WA_W] | (diff[WA_W-1:0] >= WA_W'(REG_NUM)), diff[WA_W-1:0]};
    endfunction

    logic [WA_W:0]                wr_dec;
    logic [WA_W:0]                rd_dec;
    logic [AXIL_DATA_WIDTH-1:0]   regs_q [REG_NUM];
    logic [AXIL_DATA_WIDTH-1:0]   regs_d [REG_NUM];
    logic [REG_NUM-1:0]           pulse_q;
    logic [REG_NUM-1:0]           pulse_d;
    logic                         unused_bits;

    assign wr_dec      = decode(wr_addr_i[AXIL_ADDR_WIDTH-1:2]);
    assign rd_dec      = decode(rd_addr_i[AXIL_ADDR_WIDTH-1:2]);
    assign unused_bits = ^{wr_addr_i[1:0], rd_addr_i[1:0], status_in_i};

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (wr_en_i && !wr_dec[WA_W]) begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (wr_dec[WA_W-1:0] == WA_W'(i) && !RO_MASK[i]) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < AXIL_STRB_WIDTH; b++) begin
                        if (wr_strb_i[b]) regs_d[i][8*b +: 8] = wr_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (!rd_dec[WA_W] && rd_dec[WA_W-1:0] == WA_W'(i)) begin
                rd_data_o = RO_MASK[i] ? status_in_i[AXIL_DATA_WIDTH*i +: AXIL_DATA_WIDTH]
                                       : regs_q[i];
            end
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_out
        assign reg_out_o[AXIL_DATA_WIDTH*g +: AXIL_DATA_WIDTH] = regs_q[g];
    end

    assign reg_wr_pulse_o = pulse_q;

endmodule

// File: rtl/axil_csr_slave.sv
// AXI-Lite CSR slave: independent AW/W holding registers joined by a
// collect/commit/respond write FSM, and a two-state read FSM.
module axil_csr_slave
    import axil_csr_slave_pkg::*;
#(
    parameter int                         AXIL_ADDR_WIDTH = 32,
    parameter int                         REG_NUM         = 16,
    parameter logic [AXIL_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter logic [REG_NUM-1:0]         RO_MASK         = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    axil_csr_slave_if.slave                    bus,
    output logic [REG_NUM*AXIL_DATA_WIDTH-1:0] reg_out,
    output logic [REG_NUM-1:0]                 reg_wr_pulse,
    input  logic [REG_NUM*AXIL_DATA_WIDTH-1:0] status_in
);
    w_state_e                   w_state_q;
    r_state_e                   r_state_q;
    logic                       aw_held_q;
    logic                       w_held_q;
    logic [AXIL_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXIL_DATA_WIDTH-1:0] w_data_q;
    logic [AXIL_STRB_WIDTH-1:0] w_strb_q;
    logic                       bvalid_q;
    logic                       arready_q;
    logic                       rvalid_q;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q;
    logic                       aw_hs;
    logic                       w_hs;
    logic [AXIL_DATA_WIDTH-1:0] rd_data;

    // Readies come only from hold/state flops, so no valid-to-ready path exists.
    assign bus.awready_s = ~aw_held_q;
    assign bus.wready_s  = ~w_held_q;
    assign bus.bvalid_s  = bvalid_q;
    assign bus.arready_s = arready_q;
    assign bus.rvalid_s  = rvalid_q;
    assign bus.rdata_s   = rdata_q;

    assign aw_hs = bus.awvalid_s & ~aw_held_q;
    assign w_hs  = bus.wvalid_s & ~w_held_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= bus.awaddr_s;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= bus.wdata_s;
                w_strb_q <= bus.wstrb_s;
            end
            case (w_state_q)
                W_COLLECT: begin
                    // Enter commit on the edge of the second handshake, not one cycle later.
                    if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) w_state_q <= W_COMMIT;
                end
                W_COMMIT: begin
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (bus.bready_s) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_COLLECT;
                    end
                end
                default: w_state_q <= W_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (bus.arvalid_s) begin
                        rdata_q   <= rd_data;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rready_s) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    axil_csr_slave_bank #(
        .AXIL_ADDR_WIDTH (AXIL_ADDR_WIDTH),
        .REG_NUM         (REG_NUM),
        .BASE_ADDR       (BASE_ADDR),
        .RO_MASK         (RO_MASK)
    ) u_bank (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (w_state_q == W_COMMIT),
        .wr_addr_i      (aw_addr_q),
        .wr_data_i      (w_data_q),
        .wr_strb_i      (w_strb_q),
        .rd_addr_i      (bus.araddr_s),
        .rd_data_o      (rd_data),
        .reg_out_o      (reg_out),
        .reg_wr_pulse_o (reg_wr_pulse),
        .status_in_i    (status_in)
    );

endmodule
